sp_ram_arbiter: RTL
===================

// Module: sp_ram_arbiter
// PURPOSE
//  Shares one single-port SRAM (cs/oe/addr/W_req/W_data/R_data, 1 access/cycle) between NUM_REQ
//  ConvAcc clients (e.g. ifmap loader, weight loader, psum writer). Round-robin grant, optional lock
//  for bursts, registered RAM command stage, read data routed back to the issuing client.
// PARAMETERS
//  NUM_REQ  3                 number of requesters (2..8)
//  ADDR_W   `ADDR_BUS_WIDTH   RAM address width
//  DATA_W   `DATA_BUS_WIDTH   RAM data width
//  RD_LAT   1                 RAM read latency, cycles from registered cs/oe to R_data (1..4)
// PORTS
//  clk         in   1               clock, all logic on rising edge
//  rst_n       in   1               asynchronous active-low reset
//  req_i       in   NUM_REQ         per-client access request, held until granted
//  we_i        in   NUM_REQ         per-client 1=write 0=read
//  lock_i      in   NUM_REQ         per-client keep-grant hint for next beat
//  addr_i      in   NUM_REQ*ADDR_W  packed addresses, client i at [i*ADDR_W +: ADDR_W]
//  wdata_i     in   NUM_REQ*DATA_W  packed write data
//  gnt_o       out  NUM_REQ         one-hot accept, combinational from req_i/state
//  rvalid_o    out  NUM_REQ         one-hot read-data valid
//  rdata_o     out  DATA_W          read data, qualified by rvalid_o
//  ram_cs      out  1               RAM chip select
//  ram_oe      out  1               RAM read enable
//  ram_addr    out  ADDR_W          RAM address
//  ram_W_req   out  1               RAM write enable
//  ram_W_data  out  DATA_W          RAM write data
//  ram_R_data  in   DATA_W          RAM read data
// BEHAVIOUR
//  Reset: gnt_o/rvalid_o/rdata_o/ram_* = 0, rr_ptr = 0, state ARB, in-flight tag pipe cleared.
//  Transfer accepted in cycle t when req_i[i] & gnt_o[i]; at most one gnt_o bit per cycle.
//  gnt_o = 0 whenever req_i = 0.
//  Arbitration in ARB: first requesting index scanning rr_ptr, rr_ptr+1, ... (mod NUM_REQ).
//  On accept, rr_ptr <= winner+1 (wraps NUM_REQ-1 -> 0).
//  FSM:
//   ARB  -> LOCK(owner=i) on accept with lock_i[i]=1.
//   LOCK: only owner eligible; others see gnt_o=0.
//   LOCK -> ARB when owner accepts with lock_i=0, or owner req_i=0 for a cycle (no grant that cycle).
//   rr_ptr advances past owner on LOCK exit.
//  Command stage (t+1): ram_cs=1, ram_addr=addr_i[i], ram_oe=~we_i[i], ram_W_req=we_i[i],
//   ram_W_data=wdata_i[i] (write) else 0. All ram_* are 0 in cycles with no accept at t.
//  Read return: tag {valid,idx} shifts through RD_LAT-deep pipe. At t+1+RD_LAT:
//   rvalid_o[idx]=1 for one cycle; rdata_o=ram_R_data, combinational pass-through.
//  rdata_o = 0 when no rvalid.
//  Writes produce no rvalid. Accepted transfers are never dropped or reordered.
//  Back-to-back reads: one per cycle, full throughput.
//  Write at t then read of same address at t+1: RAM order preserved, read returns new data.
//  Simultaneous req from all clients: exactly one granted; others hold req_i, addr_i, we_i, wdata_i stable.
//  Client may change addr/we only after its gnt.
//  rst_n low mid-operation: in-flight reads discarded, no rvalid after release, FSM to ARB, rr_ptr 0.
//  lock_i of a non-granted client is ignored.
// TESTING
//  1 RAM[0x10]=0xDEADBEEF, req0 read 0x10 at t (RD_LAT=1):
//    gnt_o=001@t; ram_cs=1, ram_oe=1, ram_addr=0x10 @t+1; rvalid_o=001, rdata_o=0xDEADBEEF @t+2.
//  2 req_i=111 held, all reads, no lock: gnt order 0,1,2,0,1,2; rvalid follows same order 2 cycles later.
//  3 req1 lock_i=1 for 3 beats then lock_i=0 on 4th, req0/req2 held:
//    gnt 1,1,1,1 then 2, then 0.
//  4 client2 write 0x5A5A5A5A to 0x20 @t, client0 read 0x20 @t+1:
//    ram_W_req=1@t+1; rvalid_o=001, rdata_o=0x5A5A5A5A @t+3.
//  5 two reads in flight, rst_n=0 one cycle:
//    all outputs 0 immediately; no rvalid after release; next req_i=110 grants 1 first.
//  6 req_i=0 for 10 cycles: ram_cs, ram_oe, ram_W_req, gnt_o, rvalid_o all 0.

Source files
------------

// File: rtl/sp_ram_arbiter.sv
`ifndef ADDR_BUS_WIDTH
`define ADDR_BUS_WIDTH 16
`endif
`ifndef DATA_BUS_WIDTH
`define DATA_BUS_WIDTH 32
`endif
// Purpose: round-robin arbiter with burst lock, sharing one single-port SRAM among NUM_REQ clients.
// Latency: grant in the request cycle, RAM command 1 cycle later, read data 1+RD_LAT cycles after accept.
// Backpressure: a client holds req/addr/we/wdata until gnt_o; no buffering, one access per cycle.
module sp_ram_arbiter #(
  parameter int NUM_REQ = 3,
  parameter int ADDR_W  = `ADDR_BUS_WIDTH,
  parameter int DATA_W  = `DATA_BUS_WIDTH,
  parameter int RD_LAT  = 1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_REQ-1:0]        req_i,
  input  logic [NUM_REQ-1:0]        we_i,
  input  logic [NUM_REQ-1:0]        lock_i,
  input  logic [NUM_REQ*ADDR_W-1:0] addr_i,
  input  logic [NUM_REQ*DATA_W-1:0] wdata_i,
  output logic [NUM_REQ-1:0]        gnt_o,
  output logic [NUM_REQ-1:0]        rvalid_o,
  output logic [DATA_W-1:0]         rdata_o,
  output logic                      ram_cs,
  output logic                      ram_oe,
  output logic [ADDR_W-1:0]         ram_addr,
  output logic                      ram_W_req,
  output logic [DATA_W-1:0]         ram_W_data,
  input  logic [DATA_W-1:0]         ram_R_data
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef logic [IDX_W-1:0] idx_t;
  typedef enum logic {ARB, LOCK} state_t;
  typedef struct packed {
    logic vld;
    idx_t idx;
  } tag_t;

  state_t state;
  idx_t   rr_ptr;
  idx_t   owner;
  idx_t   win;
  idx_t   cmd_idx;
  logic   accept;
  logic [NUM_REQ-1:0] gnt;
  tag_t   tag_pipe [RD_LAT];

  logic [NUM_REQ-1:0][ADDR_W-1:0] addr_arr;
  logic [NUM_REQ-1:0][DATA_W-1:0] wdata_arr;

  assign addr_arr  = addr_i;
  assign wdata_arr = wdata_i;

  function automatic idx_t nxt(input idx_t i);
    return (int'(i) == NUM_REQ - 1) ? '0 : i + 1'b1;
  endfunction

  // Scan from the highest offset down so the lowest offset from rr_ptr wins.
  always_comb begin
    int   s;
    idx_t cand;
    s    = 0;
    cand = '0;
    win  = '0;
    gnt  = '0;
    if (state == LOCK) begin
      win        = owner;
      gnt[owner] = req_i[owner];
    end else begin
      for (int k = NUM_REQ - 1; k >= 0; k--) begin
        s = int'(rr_ptr) + k;
        if (s >= NUM_REQ) s = s - NUM_REQ;
        cand = idx_t'(s);
        if (req_i[cand]) win = cand;
      end
      if (|req_i) gnt[win] = 1'b1;
    end
  end

  assign accept = |gnt;
  assign gnt_o  = rst_n ? gnt : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ARB;
      rr_ptr     <= '0;
      owner      <= '0;
      cmd_idx    <= '0;
      ram_cs     <= 1'b0;
      ram_oe     <= 1'b0;
      ram_W_req  <= 1'b0;
      ram_addr   <= '0;
      ram_W_data <= '0;
    end else begin
      ram_cs     <= accept;
      ram_oe     <= accept & ~we_i[win];
      ram_W_req  <= accept & we_i[win];
      ram_addr   <= accept ? addr_arr[win] : '0;
      ram_W_data <= (accept & we_i[win]) ? wdata_arr[win] : '0;
      cmd_idx    <= win;
      if (accept) rr_ptr <= nxt(win);
      case (state)
        ARB: begin
          if (accept && lock_i[win]) begin
            state <= LOCK;
            owner <= win;
          end
        end
        LOCK: begin
          // Owner dropping req ends the burst without a grant that cycle.
          if (!req_i[owner] || !lock_i[owner]) begin
            state  <= ARB;
            rr_ptr <= nxt(owner);
          end
        end
        default: state <= ARB;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < RD_LAT; i++) tag_pipe[i] <= '0;
    end else begin
      tag_pipe[0] <= tag_t'{vld: ram_cs & ram_oe, idx: cmd_idx};
      for (int i = 1; i < RD_LAT; i++) tag_pipe[i] <= tag_pipe[i-1];
    end
  end

  always_comb begin
    rvalid_o = '0;
    rdata_o  = '0;
    if (tag_pipe[RD_LAT-1].vld) begin
      rvalid_o[tag_pipe[RD_LAT-1].idx] = 1'b1;
      rdata_o                          = ram_R_data;
    end
  end

endmodule
